// File: rtl/clock_set_driver.sv
// rtl/clock_set_driver.sv - drives digital_clock set/incr/dcr buttons to move one field to a target value
// Optional feature: define CLKSET_ALARM_EN to accept field 7 (alarm hours).
module clock_set_driver #(
    parameter int PULSE_CYC = 2,
    parameter int GAP_CYC   = 2,
    parameter int NUM_MODES = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  field,
    input  logic [11:0] target,
    input  logic [11:0] current,
    output logic        set,
    output logic        incr,
    output logic        dcr,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE, S_CALC, S_ENTER, S_ADJ, S_EXIT, S_DONE, S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  field_q, field_d;
    logic [11:0] tgt_q, tgt_d;
    logic [11:0] cur_q, cur_d;
    logic [11:0] steps_q, steps_d;
    logic [11:0] rem_q, rem_d;
    logic        down_q, down_d;
    logic [7:0]  tick_q, tick_d;
    logic        high_q, high_d;
    logic        set_q, set_d;
    logic        incr_q, incr_d;
    logic        dcr_q, dcr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic [11:0] lo, m, c_off, t_off, diff, calc_steps, exit_n;
    logic        field_ok, reject, calc_down;

    assign exit_n = 12'(NUM_MODES) - {9'd0, field_q};

    // Shortest-path step count for the latched request, evaluated in CALC.
    always_comb begin
        lo       = '0;
        m        = 12'd1;
        field_ok = 1'b1;
        case (field_q)
            3'd1: m = 12'd24;
            3'd2: m = 12'd60;
            3'd3: m = 12'd60;
            3'd4: begin lo = 12'd1; m = 12'd31; end
            3'd5: begin lo = 12'd1; m = 12'd12; end
            3'd6: m = 12'd1;
`ifdef CLKSET_ALARM_EN
            3'd7: m = 12'd24;
`else
            3'd7: field_ok = 1'b0;
`endif
            default: field_ok = 1'b0;
        endcase
        c_off      = cur_q - lo;
        t_off      = tgt_q - lo;
        diff       = (t_off >= c_off) ? (t_off - c_off) : (t_off + m - c_off);
        reject     = 1'b0;
        calc_steps = '0;
        calc_down  = 1'b0;
        if (!field_ok) begin
            reject = 1'b1;
        end else if (field_q == 3'd6) begin
            if (tgt_q > cur_q) begin
                calc_steps = tgt_q - cur_q;
            end else begin
                calc_steps = cur_q - tgt_q;
                calc_down  = 1'b1;
            end
        end else if (tgt_q < lo || t_off >= m || c_off >= m) begin
            reject = 1'b1;
        end else if (diff != '0) begin
            if (diff <= (m >> 1)) begin
                calc_steps = diff;
            end else begin
                calc_steps = m - diff;
                calc_down  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        field_d = field_q;
        tgt_d   = tgt_q;
        cur_d   = cur_q;
        steps_d = steps_q;
        rem_d   = rem_q;
        down_d  = down_q;
        tick_d  = tick_q;
        high_d  = high_q;
        set_d   = set_q;
        incr_d  = incr_q;
        dcr_d   = dcr_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                set_d  = 1'b0;
                incr_d = 1'b0;
                dcr_d  = 1'b0;
                if (start) begin
                    field_d = field;
                    tgt_d   = target;
                    cur_d   = current;
                    busy_d  = 1'b1;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (reject) begin
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end else begin
                    // Enter with the gap already expired so the first set launches at once.
                    steps_d = calc_steps;
                    down_d  = calc_down;
                    rem_d   = {9'd0, field_q};
                    high_d  = 1'b0;
                    tick_d  = 8'(GAP_CYC - 1);
                    state_d = S_ENTER;
                end
            end
            S_ENTER, S_ADJ, S_EXIT: begin
                tick_d = tick_q + 8'd1;
                if (high_q) begin
                    if (tick_q == 8'(PULSE_CYC - 1)) begin
                        set_d  = 1'b0;
                        incr_d = 1'b0;
                        dcr_d  = 1'b0;
                        high_d = 1'b0;
                        tick_d = '0;
                    end
                end else if (tick_q == 8'(GAP_CYC - 1)) begin
                    high_d = 1'b1;
                    tick_d = '0;
                    if (rem_q != '0) begin
                        rem_d = rem_q - 12'd1;
                        if (state_q == S_ADJ) begin
                            incr_d = !down_q;
                            dcr_d  = down_q;
                        end else begin
                            set_d = 1'b1;
                        end
                    end else if (state_q == S_ENTER && steps_q != '0) begin
                        state_d = S_ADJ;
                        rem_d   = steps_q - 12'd1;
                        incr_d  = !down_q;
                        dcr_d   = down_q;
                    end else if (state_q != S_EXIT && exit_n != '0) begin
                        state_d = S_EXIT;
                        rem_d   = exit_n - 12'd1;
                        set_d   = 1'b1;
                    end else begin
                        high_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE, S_ERR: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            field_q <= '0;
            tgt_q   <= '0;
            cur_q   <= '0;
            steps_q <= '0;
            rem_q   <= '0;
            down_q  <= 1'b0;
            tick_q  <= '0;
            high_q  <= 1'b0;
            set_q   <= 1'b0;
            incr_q  <= 1'b0;
            dcr_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            field_q <= field_d;
            tgt_q   <= tgt_d;
            cur_q   <= cur_d;
            steps_q <= steps_d;
            rem_q   <= rem_d;
            down_q  <= down_d;
            tick_q  <= tick_d;
            high_q  <= high_d;
            set_q   <= set_d;
            incr_q  <= incr_d;
            dcr_q   <= dcr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign set  = set_q;
    assign incr = incr_q;
    assign dcr  = dcr_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_clock_set_driver.sv
// tb/tb_clock_set_driver.sv - self-checking bench for clock_set_driver
module tb_clock_set_driver;

    localparam int PULSE = 2;
    localparam int GAP   = 2;
`ifdef CLKSET_ALARM_EN
    localparam bit ALARM = 1'b1;
`else
    localparam bit ALARM = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  field = '0;
    logic [11:0] target = '0;
    logic [11:0] current = '0;
    logic        set, incr, dcr, busy, done, err;

    int n_chk  = 0;
    int n_fail = 0;

    clock_set_driver #(.PULSE_CYC(PULSE), .GAP_CYC(GAP), .NUM_MODES(8)) dut (
        .clock(clock), .reset(reset), .start(start), .field(field),
        .target(target), .current(current), .set(set), .incr(incr),
        .dcr(dcr), .busy(busy), .done(done), .err(err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  f;
        logic [11:0] c;
        logic [11:0] t;
        int          e_err;
        int          e_s1;
        int          e_inc;
        int          e_dcr;
        int          e_s2;
        bit          inject;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Expected button counts from the field range rules, in plain integer arithmetic.
    function automatic void model(input int f, input int c, input int t,
                                  output int e, output int s1, output int inc,
                                  output int dc, output int s2);
        int lo, m, dd;
        e = 0; s1 = f; s2 = 8 - f; inc = 0; dc = 0; lo = 0; m = 24;
        if (f == 0 || (f == 7 && !ALARM)) begin
            e = 1; s1 = 0; s2 = 0;
            return;
        end
        if (f == 6) begin
            if (t > c) inc = t - c; else dc = c - t;
            return;
        end
        case (f)
            2, 3: m = 60;
            4: begin lo = 1; m = 31; end
            5: begin lo = 1; m = 12; end
            default: m = 24;
        endcase
        if (t < lo || c < lo || t - lo >= m || c - lo >= m) begin
            e = 1; s1 = 0; s2 = 0;
            return;
        end
        dd = ((t - c) % m + m) % m;
        if (dd != 0) begin
            if (2 * dd <= m) inc = dd; else dc = m - dd;
        end
    endfunction

    task automatic run_req(input logic [2:0] f, input logic [11:0] c, input logic [11:0] t,
                           input int e_err, input int e_s1, input int e_inc,
                           input int e_dcr, input int e_s2, input bit inject);
        int exp_q[$];
        int got_q[$];
        int n = 0, first_at = 0, err_at = 0, hi = 0, lo = 0;
        int tbad = 0, obad = 0, bbad = 0, ndone = 0, nerr = 0, prev = 0, cur_l, mism = 0;
        bit fin = 0;
        for (int i = 0; i < e_s1; i++) exp_q.push_back(1);
        for (int i = 0; i < e_inc; i++) exp_q.push_back(2);
        for (int i = 0; i < e_dcr; i++) exp_q.push_back(3);
        for (int i = 0; i < e_s2; i++) exp_q.push_back(1);
        @(negedge clock);
        start = 1'b1; field = f; current = c; target = t;
        while (!fin && n < 20000) begin
            @(negedge clock);
            n++;
            if (n == 1) start = 1'b0;
            if (inject && n == 9) begin
                start = 1'b1; field = 3'd2; current = 12'd0; target = 12'd30;
            end
            if (inject && n == 10) start = 1'b0;
            cur_l = set ? 1 : incr ? 2 : dcr ? 3 : 0;
            if (int'(set) + int'(incr) + int'(dcr) > 1) obad++;
            if (!busy) bbad++;
            if (cur_l != 0) begin
                if (prev == 0) begin
                    got_q.push_back(cur_l);
                    if (got_q.size() == 1) first_at = n;
                    else if (lo != GAP) tbad++;
                    hi = 0;
                end else if (cur_l != prev) begin
                    tbad++;
                end
                hi++;
            end else begin
                if (prev != 0) begin
                    if (hi != PULSE) tbad++;
                    lo = 0;
                end
                lo++;
            end
            prev = cur_l;
            if (done) ndone++;
            if (err) begin nerr++; err_at = n; end
            if (done || err) fin = 1'b1;
        end
        chk("completed", int'(fin), 1);
        chk("err_count", nerr, e_err);
        chk("done_count", ndone, (e_err != 0) ? 0 : 1);
        chk("pulse_total", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            if (exp_q[i] != got_q[i]) mism++;
        chk("pulse_order", mism, 0);
        if (exp_q.size() > 0) chk("first_set_cycle", first_at, 3);
        if (e_err != 0) chk("err_cycle", err_at, 2);
        chk("pulse_timing", tbad, 0);
        chk("one_hot", obad, 0);
        chk("busy_hold", bbad, 0);
        @(negedge clock);
        chk("idle_after", int'({busy, done, err, set, incr, dcr}), 0);
    endtask

    initial begin
        int k, n, quiet, e, s1, inc, dc, s2, f, c, t, m_g, lo_g;
        bit previ;

        tbl.push_back('{3'd1, 12'd22,   12'd3,    0, 1, 5,   0,  7, 1'b1});
        tbl.push_back('{3'd2, 12'd10,   12'd50,   0, 2, 0,   20, 6, 1'b0});
        tbl.push_back('{3'd4, 12'd31,   12'd1,    0, 4, 1,   0,  4, 1'b0});
        tbl.push_back('{3'd3, 12'd17,   12'd17,   0, 3, 0,   0,  5, 1'b0});
        tbl.push_back('{3'd6, 12'd2017, 12'd2015, 0, 6, 0,   2,  2, 1'b0});
        tbl.push_back('{3'd5, 12'd1,    12'd13,   1, 0, 0,   0,  0, 1'b0});
`ifdef CLKSET_ALARM_EN
        tbl.push_back('{3'd7, 12'd0,    12'd23,   0, 7, 0,   1,  1, 1'b0});
`else
        tbl.push_back('{3'd7, 12'd0,    12'd23,   1, 0, 0,   0,  0, 1'b0});
`endif
        tbl.push_back('{3'd0, 12'd0,    12'd0,    1, 0, 0,   0,  0, 1'b0});
        tbl.push_back('{3'd4, 12'd5,    12'd0,    1, 0, 0,   0,  0, 1'b0});
        tbl.push_back('{3'd2, 12'd59,   12'd60,   1, 0, 0,   0,  0, 1'b0});
        tbl.push_back('{3'd1, 12'd0,    12'd12,   0, 1, 12,  0,  7, 1'b0});
        tbl.push_back('{3'd1, 12'd0,    12'd13,   0, 1, 0,   11, 7, 1'b0});
        tbl.push_back('{3'd5, 12'd12,   12'd1,    0, 5, 1,   0,  3, 1'b0});
        tbl.push_back('{3'd6, 12'd0,    12'd300,  0, 6, 300, 0,  2, 1'b0});

        repeat (3) @(negedge clock);
        chk("reset_outputs", int'({set, incr, dcr, busy, done, err}), 0);
        reset = 1'b0;
        @(negedge clock);
        chk("idle_outputs", int'({set, incr, dcr, busy, done, err}), 0);

        for (int i = 0; i < tbl.size(); i++)
            run_req(tbl[i].f, tbl[i].c, tbl[i].t, tbl[i].e_err, tbl[i].e_s1,
                    tbl[i].e_inc, tbl[i].e_dcr, tbl[i].e_s2, tbl[i].inject);

        // Reset while the third incr pulse of a 5-step hours move is high.
        @(negedge clock);
        start = 1'b1; field = 3'd1; current = 12'd22; target = 12'd3;
        k = 0; n = 0; previ = 1'b0;
        while (k < 3 && n < 200) begin
            @(negedge clock);
            n++;
            if (n == 1) start = 1'b0;
            if (incr && !previ) k++;
            previ = incr;
        end
        chk("rst_reached_adj", k, 3);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_mid_outputs", int'({set, incr, dcr, busy, done, err}), 0);
        reset = 1'b0;
        quiet = 0;
        repeat (6) begin
            @(negedge clock);
            quiet += int'(set) + int'(incr) + int'(dcr) + int'(busy) + int'(done) + int'(err);
        end
        chk("rst_stays_idle", quiet, 0);
        run_req(3'd2, 12'd10, 12'd50, 0, 2, 0, 20, 6, 1'b0);

        for (int r = 0; r < 40; r++) begin
            f    = int'($urandom_range(0, 7));
            m_g  = (f == 2 || f == 3) ? 60 : (f == 4) ? 31 : (f == 5) ? 12 : 24;
            lo_g = (f == 4 || f == 5) ? 1 : 0;
            if (f == 6) begin
                c = 2000 + int'($urandom_range(0, 60));
                t = 2000 + int'($urandom_range(0, 60));
            end else if ($urandom_range(0, 3) != 0) begin
                c = lo_g + int'($urandom_range(0, m_g - 1));
                t = lo_g + int'($urandom_range(0, m_g - 1));
            end else begin
                c = int'($urandom_range(0, 63));
                t = int'($urandom_range(0, 63));
            end
            model(f, c, t, e, s1, inc, dc, s2);
            run_req(3'(f), 12'(c), 12'(t), e, s1, inc, dc, s2, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
